// File: rtl/cam_pkg.sv
// Shared types and constants for the frame sender: FSM state encoding,
// frame header sync bytes and the default 115200-baud divisor.
package cam_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    LATCH     = 4'd2,
    HDR0      = 4'd3,
    HDR1      = 4'd4,
    START_BIT = 4'd5,
    DATA_BITS = 4'd6,
    STOP_BIT  = 4'd7,
    DONE      = 4'd8
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  localparam int CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/frame_uart_sender_if.sv
// Control handshake (start/done/busy) and frame-RAM read port of the sender.
// master = the sender itself, slave = capture controller plus frame RAM.
interface frame_uart_sender_if #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 10
);

  logic              start;
  logic              done;
  logic              busy;
  logic              readEnable;
  logic [ADDR_W-1:0] readAddr;
  logic [PIX_W-1:0]  readData;

  modport master (
    input  start,
    input  readData,
    output done,
    output busy,
    output readEnable,
    output readAddr
  );

  modport slave (
    output start,
    output readData,
    input  done,
    input  busy,
    input  readEnable,
    input  readAddr
  );

endinterface

// File: rtl/frame_uart_sender_uart_tx_byte.sv
// 8N1 serialiser for one byte: start bit, 8 data bits LSB first, stop bit.
// byte_done is high in the last cycle of the stop bit; load is ignored unless idle.
module uart_tx_byte
  import cam_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            phase_q, phase_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    baud_end  = (baud_q == BAUD_LAST);

    case (phase_q)
      IDLE: begin
        if (load) begin
          phase_d = START_BIT;
          shift_d = data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START_BIT: begin
        if (baud_end) begin
          phase_d = DATA_BITS;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA_BITS: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            phase_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP_BIT: begin
        if (baud_end) begin
          phase_d   = IDLE;
          baud_d    = '0;
          byte_done = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        phase_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level is decoded from the next phase so tx leaves a flop cleanly.
    case (phase_d)
      START_BIT: tx_d = 1'b0;
      DATA_BITS: tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: rtl/frame_uart_sender.sv
// Reads every pixel of the captured frame and sends its 8 MSBs as 8N1 UART.
// Define FRAME_HEADER_EN to prefix each frame with the sync bytes 0xA5, 0x5A.
module frame_uart_sender
  import cam_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int PIX_W        = 10,
  parameter int NUM_PIX      = 4096,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic                clock,
  input  logic                reset,
  frame_uart_sender_if.master bus,
  output logic                tx
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIX - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              load;
  logic [7:0]        load_data;
  logic              byte_done;

`ifdef FRAME_HEADER_EN
  // 1: SYNC0 in flight, 2: SYNC1 in flight, 0: pixel data
  logic [1:0] hdr_q, hdr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr_q <= 2'd0;
    end else begin
      hdr_q <= hdr_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    load      = 1'b0;
    load_data = bus.readData[PIX_W-1 -: 8];
`ifdef FRAME_HEADER_EN
    hdr_d     = hdr_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pix_d = '0;
`ifdef FRAME_HEADER_EN
          state_d = HDR0;
`else
          state_d = FETCH;
`endif
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        load    = 1'b1;
        state_d = START_BIT;
      end
`ifdef FRAME_HEADER_EN
      HDR0: begin
        load      = 1'b1;
        load_data = SYNC0;
        hdr_d     = 2'd1;
        state_d   = START_BIT;
      end
      HDR1: begin
        load      = 1'b1;
        load_data = SYNC1;
        hdr_d     = 2'd2;
        state_d   = START_BIT;
      end
`endif
      // START_BIT covers the whole byte in flight; uart_tx_byte steps
      // through the start, data and stop phases on its own.
      START_BIT: begin
        if (byte_done) begin
`ifdef FRAME_HEADER_EN
          if (hdr_q == 2'd1) begin
            state_d = HDR1;
          end else if (hdr_q == 2'd2) begin
            hdr_d   = 2'd0;
            state_d = FETCH;
          end else
`endif
          if (pix_q == PIX_LAST) begin
            state_d = DONE;
          end else begin
            pix_d   = pix_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.readEnable = (state_q == FETCH);
  assign bus.readAddr   = pix_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

  // Only the top byte of each pixel is transmitted.
  if (PIX_W > 8) begin : g_pix_lsbs
    logic pix_lsbs_unused;
    assign pix_lsbs_unused = ^bus.readData[PIX_W-9:0];
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .data     (load_data),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_frame_uart_sender.sv
// Directed bench for frame_uart_sender: 4-pixel frame, 4 clocks per bit,
// RAM returns {addr, 2'b11}; tx is decoded back into bytes on the falling edge.
module tb_frame_uart_sender;

  localparam int ADDR_W  = 12;
  localparam int PIX_W   = 10;
  localparam int NUM_PIX = 4;
  localparam int CPB     = 4;
`ifdef FRAME_HEADER_EN
  localparam int HDR_N     = 2;
  localparam int DONE_LAT  = 251;
  localparam int PIX_OFF   = 82;
`else
  localparam int HDR_N     = 0;
  localparam int DONE_LAT  = 169;
  localparam int PIX_OFF   = 0;
`endif
  localparam int NBYTES = NUM_PIX + HDR_N;

  logic clock = 1'b0;
  logic reset;
  logic tx;
  logic mon_clr;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  frame_uart_sender_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  frame_uart_sender #(
    .ADDR_W      (ADDR_W),
    .PIX_W       (PIX_W),
    .NUM_PIX     (NUM_PIX),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous frame RAM model, one cycle read latency
  always @(posedge clock) begin
    if (bus.readEnable) bus.readData <= {bus.readAddr[7:0], 2'b11};
  end

  // Bus monitor
  int         re_cnt, done_cnt, done_cyc;
  logic [11:0] addr_log [16];
  bit         re_prev, re_double, tx_low_seen;

  always @(negedge clock) begin
    if (mon_clr) begin
      re_cnt      <= 0;
      done_cnt    <= 0;
      done_cyc    <= -1;
      re_prev     <= 1'b0;
      re_double   <= 1'b0;
      tx_low_seen <= 1'b0;
    end else begin
      if (bus.readEnable) begin
        if (re_cnt < 16) addr_log[re_cnt] <= bus.readAddr;
        re_cnt <= re_cnt + 1;
        if (re_prev) re_double <= 1'b1;
      end
      re_prev <= bus.readEnable;
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (!tx) tx_low_seen <= 1'b1;
    end
  end

  // UART decoder: sample n after the falling edge; data bit i centred at 4i+6
  int         nbytes, dec_cnt, run_len;
  bit         dec_active, prev_tx, need_lo, stop_err;
  logic [7:0] dec_shift;
  logic [7:0] byte_log [16];
  int         lo_first [16];
  int         hi_before [16];

  always @(negedge clock) begin
    if (mon_clr || reset) begin
      nbytes     <= 0;
      dec_cnt    <= 0;
      run_len    <= 0;
      dec_active <= 1'b0;
      prev_tx    <= 1'b1;
      need_lo    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      prev_tx <= tx;
      run_len <= (tx == prev_tx) ? run_len + 1 : 1;
      if (need_lo && tx && !prev_tx) begin
        if (nbytes < 16) lo_first[nbytes] <= run_len;
        need_lo <= 1'b0;
      end
      if (!dec_active) begin
        if (prev_tx && !tx) begin
          dec_active <= 1'b1;
          dec_cnt    <= 1;
          need_lo    <= 1'b1;
          if (nbytes < 16) hi_before[nbytes] <= run_len;
        end
      end else begin
        dec_cnt <= dec_cnt + 1;
        if (dec_cnt >= 6 && dec_cnt <= 34 && ((dec_cnt - 6) % CPB) == 0)
          dec_shift <= {tx, dec_shift[7:1]};
        if (dec_cnt == 38) begin
          if (!tx) stop_err <= 1'b1;
          if (nbytes < 16) byte_log[nbytes] <= dec_shift;
          nbytes     <= nbytes + 1;
          dec_active <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_at(input int t);
    goto_cyc(t);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clock);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("done_within_budget", 32'(got), 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    if (HDR_N == 2 && i == 0) return 8'hA5;
    if (HDR_N == 2 && i == 1) return 8'h5A;
    return 8'(i - HDR_N);
  endfunction

  task automatic check_frame(input string tag, input int s);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_lat"}, 32'(done_cyc - s), 32'(DONE_LAT));
    check({tag, "_nbytes"}, 32'(nbytes), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(byte_log[i]), 32'(exp_byte(i)));
    check({tag, "_re_cnt"}, 32'(re_cnt), 32'(NUM_PIX));
    for (int i = 0; i < NUM_PIX; i++)
      check($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(i));
    check({tag, "_re_double"}, 32'(re_double), 32'd0);
    check({tag, "_stop_err"}, 32'(stop_err), 32'd0);
  endtask

  initial begin
    int s;
    bus.start = 1'b0;
    mon_clr   = 1'b0;
    reset     = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_re", 32'(bus.readEnable), 32'd0);
    check("rst_addr", 32'(bus.readAddr), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle for 50 cycles
    clr_mon();
    repeat (50) @(negedge clock);
    check("idle_re_cnt", 32'(re_cnt), 32'd0);
    check("idle_done_cnt", 32'(done_cnt), 32'd0);
    check("idle_tx_low", 32'(tx_low_seen), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Single frame
    clr_mon();
    s = cyc + 2;
    goto_cyc(s);
    bus.start = 1'b1;
    @(negedge clock);
    check("f1_busy_start_cyc", 32'(bus.busy), 32'd0);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    @(negedge clock);
    check("f1_busy_rise", 32'(bus.busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("f1_tx_after_3", 32'(tx), (HDR_N == 0) ? 32'd0 : 32'd0);
    wait_done(400);
    @(negedge clock);
    check("f1_busy_after_done", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clock);
    check_frame("f1", s);
    check("f1_start_low", 32'(lo_first[HDR_N + 1]), 32'(CPB));
    check("f1_gap_high", 32'(hi_before[HDR_N + 1]), 32'(CPB + 2));

    // Restart attempts while busy and during the DONE cycle
    @(posedge clock);
    #1;
    clr_mon();
    s = cyc + 2;
    start_at(s);
    start_at(s + 10);
    start_at(s + 60);
    goto_cyc(s + DONE_LAT);
    bus.start = 1'b1;
    @(negedge clock);
    check("f2_done_with_start", 32'(bus.done), 32'd1);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (60) @(negedge clock);
    check_frame("f2", s);
    check("f2_busy_idle", 32'(bus.busy), 32'd0);

    // Reset during pixel byte 2 data bit 2 (a zero bit)
    @(posedge clock);
    #1;
    clr_mon();
    s = cyc + 2;
    start_at(s);
    goto_cyc(s + 100 + PIX_OFF);
    @(negedge clock);
    check("f3_tx_before_rst", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    check("f3_tx_in_rst", 32'(tx), 32'd1);
    check("f3_busy_in_rst", 32'(bus.busy), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clr_mon();
    repeat (300) @(negedge clock);
    check("f3_no_done", 32'(done_cnt), 32'd0);
    check("f3_no_tx", 32'(tx_low_seen), 32'd0);
    check("f3_no_re", 32'(re_cnt), 32'd0);

    // Fresh frame after the abort
    @(posedge clock);
    #1;
    clr_mon();
    s = cyc + 2;
    start_at(s);
    wait_done(400);
    repeat (4) @(negedge clock);
    check_frame("f4", s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
